ins_encoder: RTL and testbench
==============================

# ins_encoder

Streaming RV32I instruction encoder and program writer, the inverse of the core's I/R-type decode stage. Accepts ALU instructions as separate fields (type, aluop, rd, rs1, rs2, imm) over a valid/ready handshake. Each request is checked for legality, packed into a 32-bit instruction word, and written to consecutive words of instruction memory through a stallable write port. Used by the boot/test loader to build programs the decoder later consumes.

## Interface
Parameters:
- DEPTH, 256, instruction memory size in words
- ADDR_W, 8, word-address width; DEPTH must be ≤ 2**ADDR_W

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous restart: address and counters to 0, FSM to IDLE
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_type  in  1  0 = I-type (opcode 0010011), 1 = R-type (opcode 0110011)
- in_aluop  in  4  {funct7[5], funct3}, same packing as the decoder's aluop
- in_rd, in_rs1, in_rs2  in  5 each  register indices; rs2 is ignored for I-type
- in_imm  in  12  I-type immediate; ignored for R-type
- mem_wr_en  out  1  write request, held until acknowledged
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- mem_wr_ack  in  1  memory accepts the write this cycle
- err  out  1  one-cycle pulse: illegal request rejected
- full  out  1  DEPTH words written
- word_cnt  out  ADDR_W+1  words written since reset/clear

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - WRITE: mem_wr_en=1, in_ready=0.
  - FULL: in_ready=0, full=1.
- IDLE, in_valid & legal request: latch the encoded word into mem_wdata, go to WRITE.
- IDLE, in_valid & illegal request: err=1 for the next cycle, nothing written, stay in IDLE.
- WRITE, mem_wr_ack=1:
  - increment mem_addr and word_cnt.
  - go to FULL if word_cnt reaches DEPTH, otherwise go to IDLE.
- WRITE, mem_wr_ack=0: hold mem_addr, mem_wdata and mem_wr_en stable.
- I-type encoding: {imm[11:0], rs1, funct3, rd, 0010011}.
- R-type encoding: {0, aluop[3], 00000, rs2, rs1, funct3, rd, 0110011}.
- Legality rules:
  - I-type, aluop[3]=1: legal only when funct3=101 (SRAI). Encode imm[11:5]=0100000, shamt=imm[4:0]; in_imm[11:5] must be 0.
  - I-type, funct3 = 001 or 101 with aluop[3]=0: in_imm[11:5] must be 0.
  - R-type, aluop[3]=1: legal only when funct3 = 000 (SUB) or 101 (SRA).
- clear has priority over every state. A pending write is abandoned: mem_wr_en drops the next cycle, and no address or count increment occurs.
- mem_addr never wraps. FULL is left only via clear or rst.

## Timing
- Reset values: in_ready=1, mem_wr_en=0, mem_addr=0, mem_wdata=0, err=0, full=0, word_cnt=0, state IDLE.
- Accept on cycle N (in_valid & in_ready) gives mem_wr_en=1 with valid data at N+1.
- Ack at cycle M: in_ready=1 (or full=1) at M+1. Best-case throughput is 1 word per 2 cycles.
- Reject on cycle N: err=1 at N+1 only, and in_ready stays 1.
- All outputs are registered; there is no combinational path from in_* to mem_*.
- Ack arriving while mem_wr_en=0 is ignored.
- rst mid-write: immediate return to reset values; the partial write is not counted.

## Structure
- Shared package rv32i_pkg:
  - OP_IMM=7'b0010011, OP_REG=7'b0110011.
  - funct3 constants ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
  - FUNCT7_ALT=7'b0100000.
  - instruction type enum.
- The decoder reuses the same package.
- Sub-module ins_field_pack: purely combinational legality check plus word packing. This lets it be unit-tested against the decoder in a loop-back test.
- The top level holds the FSM, address/count registers and output registers.

## Test plan
- Reset then ADDI x1,x0,5 (type 0, aluop 0000, imm 0x005) → mem_wdata=0x00500093 at addr 0; word_cnt=1 after ack.
- SUB x3,x1,x2 (type 1, aluop 1000), ack delayed 3 cycles → 0x402081B3 held stable for 4 cycles at addr 1; in_ready low throughout.
- SRAI x5,x6,3 (type 0, aluop 1101, imm 0x003) → 0x40335293; with imm=0x023 instead → err pulse, no write, addr unchanged.
- I-type aluop 1000, and R-type aluop 1001 → each rejected with err=1 for exactly one cycle; word_cnt unchanged.
- DEPTH=4, five back-to-back legal requests → four writes at addr 0–3, then full=1 and in_ready=0; the fifth is never accepted. clear → addr 0, full=0, in_ready=1.
- clear asserted in WRITE before ack → mem_wr_en=0 next cycle, word_cnt=0; a later ack is ignored. Loop-back: every legal encoder word fed to the decoder reproduces the original rd/rs1/rs2/aluop/imm.

Source files
------------

// File: rtl/rv32i_pkg.sv
// RV32I constants and types shared by the instruction encoder and the decoder.
package rv32i_pkg;

  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_REG     = 7'b0110011;
  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic {
    INS_I = 1'b0,
    INS_R = 1'b1
  } ins_type_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } enc_state_e;

endpackage

// File: rtl/ins_encoder_if.sv
// Request handshake plus instruction-memory write port of the encoder.
interface ins_encoder_if #(
  parameter int ADDR_W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic              in_type;
  logic [3:0]        in_aluop;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [11:0]       in_imm;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_wr_ack;

  // Loader and memory side
  modport master (
    output in_valid, in_type, in_aluop, in_rd, in_rs1, in_rs2, in_imm, mem_wr_ack,
    input  in_ready, mem_wr_en, mem_addr, mem_wdata
  );

  // Encoder side
  modport slave (
    input  in_valid, in_type, in_aluop, in_rd, in_rs1, in_rs2, in_imm, mem_wr_ack,
    output in_ready, mem_wr_en, mem_addr, mem_wdata
  );

endinterface

// File: rtl/ins_field_pack.sv
// Combinational legality check and 32-bit packing of one I/R-type ALU request.
module ins_field_pack
  import rv32i_pkg::*;
(
  input  ins_type_e   ins_type,
  input  logic [3:0]  aluop,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic        legal,
  output logic [31:0] word
);

  logic [2:0]  funct3;
  logic        alt;
  logic        imm_hi_zero;
  logic [11:0] imm_field;
  logic [6:0]  funct7;

  assign funct3      = aluop[2:0];
  assign alt         = aluop[3];
  assign imm_hi_zero = (imm[11:5] == 7'd0);

  always_comb begin
    legal     = 1'b1;
    imm_field = imm;
    funct7    = 7'd0;
    word      = '0;
    if (ins_type == INS_I) begin
      // Only SRAI has an alternate I-type form; its funct7 lives in imm[11:5]
      if (alt) begin
        legal     = (funct3 == F3_SRL) && imm_hi_zero;
        imm_field = {FUNCT7_ALT, imm[4:0]};
      end else if ((funct3 == F3_SLL) || (funct3 == F3_SRL)) begin
        legal = imm_hi_zero;
      end
      word = {imm_field, rs1, funct3, rd, OP_IMM};
    end else begin
      legal  = !alt || (funct3 == F3_ADD) || (funct3 == F3_SRL);
      funct7 = alt ? FUNCT7_ALT : 7'd0;
      word   = {funct7, rs2, rs1, funct3, rd, OP_REG};
    end
  end

endmodule

// File: rtl/ins_encoder.sv
// Streaming RV32I I/R-type encoder: legality-checks requests and writes packed
// words to consecutive instruction-memory addresses through a stallable port.
//
// state | meaning
// IDLE  | ready for a request
// WRITE | word held on the memory port until acknowledged
// FULL  | DEPTH words written; only clear or rst leave
module ins_encoder
  import rv32i_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  ins_encoder_if.slave    bus,
  output logic            err,
  output logic            full,
  output logic [ADDR_W:0] word_cnt
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  enc_state_e      state;
  logic            pk_legal;
  logic [31:0]     pk_word;
  logic [ADDR_W:0] next_cnt;

  ins_field_pack u_pack (
    .ins_type (ins_type_e'(bus.in_type)),
    .aluop    (bus.in_aluop),
    .rd       (bus.in_rd),
    .rs1      (bus.in_rs1),
    .rs2      (bus.in_rs2),
    .imm      (bus.in_imm),
    .legal    (pk_legal),
    .word     (pk_word)
  );

  assign next_cnt = word_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b1;
      bus.mem_wr_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      err           <= 1'b0;
      full          <= 1'b0;
      word_cnt      <= '0;
    end else if (clear) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b1;
      bus.mem_wr_en <= 1'b0;
      bus.mem_addr  <= '0;
      err           <= 1'b0;
      full          <= 1'b0;
      word_cnt      <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (pk_legal) begin
              bus.mem_wdata <= pk_word;
              bus.mem_wr_en <= 1'b1;
              bus.in_ready  <= 1'b0;
              state         <= S_WRITE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (bus.mem_wr_ack) begin
            bus.mem_wr_en <= 1'b0;
            word_cnt      <= next_cnt;
            // Saturate so the address never wraps when DEPTH == 2**ADDR_W
            if (bus.mem_addr != ADDR_MAX) bus.mem_addr <= bus.mem_addr + 1'b1;
            if (next_cnt == DEPTH_CNT) begin
              full  <= 1'b1;
              state <= S_FULL;
            end else begin
              bus.in_ready <= 1'b1;
              state        <= S_IDLE;
            end
          end
        end
        S_FULL: begin
          full <= 1'b1;
        end
        default: begin
          state        <= S_IDLE;
          bus.in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ins_encoder.sv
// Self-checking bench for ins_encoder: behavioural encode/decode reference,
// per-cycle output scoreboard, directed cases and a randomized phase.
module tb_ins_encoder;
  import rv32i_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 3;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        clear = 1'b0;
  logic        err;
  logic        full;
  logic [AW:0] word_cnt;

  ins_encoder_if #(.ADDR_W(AW)) bus ();

  ins_encoder #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .bus      (bus),
    .err      (err),
    .full     (full),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder written from the field-layout rules with plain arithmetic
  function automatic logic [31:0] ref_encode(input int typ, input int aluop, input int rd,
                                             input int rs1, input int rs2, input int imm,
                                             output bit legal);
    longint w;
    int f3, hi, immf;
    bit alt;
    f3  = aluop % 8;
    alt = (aluop >= 8);
    hi  = imm / 32;
    if (typ == 0) begin
      if (alt)                    legal = (f3 == 5) && (hi == 0);
      else if (f3 == 1 || f3 == 5) legal = (hi == 0);
      else                        legal = 1'b1;
      immf = alt ? (32 * 32 + imm % 32) : imm;
      w = longint'(immf) * (2 ** 20) + rs1 * (2 ** 15) + f3 * (2 ** 12) + rd * (2 ** 7) + 19;
    end else begin
      legal = !alt || f3 == 0 || f3 == 5;
      w = longint'(alt ? 32 : 0) * (2 ** 25) + rs2 * (2 ** 20) + rs1 * (2 ** 15)
          + f3 * (2 ** 12) + rd * (2 ** 7) + 51;
    end
    return 32'(w);
  endfunction

  typedef struct {
    int typ, aluop, rd, rs1, rs2, imm;
  } req_t;

  req_t        pend_q[$];
  logic [31:0] wr_word_q[$];
  int          wr_addr_q[$];
  int          nwrites = 0;

  bit          m_busy = 1'b0;
  bit          m_full = 1'b0;
  bit          m_err  = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_word = '0;

  // Transaction-level model: one pending write at most, count of completed writes
  always @(posedge clk or posedge rst) begin
    bit   lg;
    req_t r;
    if (rst) begin
      m_busy = 0; m_full = 0; m_err = 0; m_cnt = 0;
      pend_q.delete();
    end else if (clear) begin
      m_busy = 0; m_full = 0; m_err = 0; m_cnt = 0;
      pend_q.delete();
    end else begin
      m_err = 0;
      if (m_busy) begin
        if (bus.mem_wr_ack) begin
          m_busy = 0;
          m_cnt++;
          if (m_cnt == DEPTH) m_full = 1;
        end
      end else if (!m_full && bus.in_valid) begin
        r.typ = int'(bus.in_type);  r.aluop = int'(bus.in_aluop);
        r.rd  = int'(bus.in_rd);    r.rs1   = int'(bus.in_rs1);
        r.rs2 = int'(bus.in_rs2);   r.imm   = int'(bus.in_imm);
        m_word = ref_encode(r.typ, r.aluop, r.rd, r.rs1, r.rs2, r.imm, lg);
        if (lg) begin
          m_busy = 1;
          pend_q.push_back(r);
        end else begin
          m_err = 1;
        end
      end
    end
  end

  logic prev_wr = 1'b0;

  // Per-cycle comparison plus decoder loop-back on every new write
  always @(negedge clk) begin
    logic [31:0] w;
    logic [2:0]  f3;
    req_t        r;
    if (rst) begin
      prev_wr = 1'b0;
    end else begin
      check("in_ready",  32'(bus.in_ready),  32'(!m_busy && !m_full));
      check("mem_wr_en", 32'(bus.mem_wr_en), 32'(m_busy));
      check("mem_addr",  32'(bus.mem_addr),  32'((m_cnt > 7) ? 7 : m_cnt));
      check("err",       32'(err),           32'(m_err));
      check("full",      32'(full),          32'(m_full));
      check("word_cnt",  32'(word_cnt),      32'(m_cnt));
      if (m_busy) check("mem_wdata", bus.mem_wdata, m_word);
      if (bus.mem_wr_en && !prev_wr) begin
        nwrites++;
        wr_word_q.push_back(bus.mem_wdata);
        wr_addr_q.push_back(int'(bus.mem_addr));
        if (pend_q.size() == 0) begin
          check("loopback_queue", 32'(0), 32'(1));
        end else begin
          r  = pend_q.pop_front();
          w  = bus.mem_wdata;
          f3 = w[14:12];
          check("lb_opcode", 32'(w[6:0]), (r.typ != 0) ? 32'h33 : 32'h13);
          check("lb_rd",  32'(w[11:7]),  32'(r.rd));
          check("lb_rs1", 32'(w[19:15]), 32'(r.rs1));
          if (r.typ != 0) begin
            check("lb_rs2",   32'(w[24:20]),     32'(r.rs2));
            check("lb_aluop", 32'({w[30], f3}),  32'(r.aluop));
          end else if (f3 == 3'd1 || f3 == 3'd5) begin
            check("lb_aluop", 32'({w[30], f3}),  32'(r.aluop));
            check("lb_imm",   32'(w[24:20]),     32'(r.imm));
          end else begin
            check("lb_aluop", 32'({1'b0, f3}),   32'(r.aluop));
            check("lb_imm",   32'(w[31:20]),     32'(r.imm));
          end
        end
      end
      prev_wr = bus.mem_wr_en;
    end
  end

  task automatic drive(input int typ, input int op, input int rd, input int rs1,
                       input int rs2, input int imm);
    bus.in_type  = typ[0];
    bus.in_aluop = op[3:0];
    bus.in_rd    = rd[4:0];
    bus.in_rs1   = rs1[4:0];
    bus.in_rs2   = rs2[4:0];
    bus.in_imm   = imm[11:0];
  endtask

  // One-cycle request; returns on the negedge where its outcome is visible
  task automatic send(input int typ, input int op, input int rd, input int rs1,
                      input int rs2, input int imm);
    @(negedge clk);
    drive(typ, op, rd, rs1, rs2, imm);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic ack_now();
    bus.mem_wr_ack = 1'b1;
    @(negedge clk);
    bus.mem_wr_ack = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    bit lg;
    int held, nw0, base;
    bus.in_valid   = 1'b0;
    bus.mem_wr_ack = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // Pin the reference encoder itself
    check("ref_addi", ref_encode(0, 0, 1, 0, 0, 5, lg), 32'h00500093);
    check("ref_addi_legal", 32'(lg), 32'd1);
    check("ref_sub",  ref_encode(1, 8, 3, 1, 2, 0, lg), 32'h402081B3);
    check("ref_srai", ref_encode(0, 13, 5, 6, 0, 3, lg), 32'h40335293);
    void'(ref_encode(0, 13, 5, 6, 0, 35, lg));
    check("ref_srai_bad_legal", 32'(lg), 32'd0);
    void'(ref_encode(1, 9, 1, 1, 1, 0, lg));
    check("ref_r1001_legal", 32'(lg), 32'd0);

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_wr_en",    32'(bus.mem_wr_en), 32'd0);
    check("rst_wdata",    bus.mem_wdata, 32'd0);
    check("rst_cnt",      32'(word_cnt), 32'd0);
    rst = 1'b0;

    // ADDI x1,x0,5
    send(0, 4'b0000, 1, 0, 0, 12'h005);
    check("addi_wr_en", 32'(bus.mem_wr_en), 32'd1);
    check("addi_word",  bus.mem_wdata, 32'h00500093);
    check("addi_addr",  32'(bus.mem_addr), 32'd0);
    ack_now();
    check("addi_cnt",   32'(word_cnt), 32'd1);
    check("addi_ready", 32'(bus.in_ready), 32'd1);

    // SUB x3,x1,x2 with ack delayed three cycles
    send(1, 4'b1000, 3, 1, 2, 0);
    held = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.mem_wr_en && bus.mem_wdata == 32'h402081B3 && !bus.in_ready && bus.mem_addr == 3'd1)
        held++;
      if (i == 3) bus.mem_wr_ack = 1'b1;
      @(negedge clk);
    end
    bus.mem_wr_ack = 1'b0;
    check("sub_held_cycles", 32'(held), 32'd4);
    check("sub_cnt", 32'(word_cnt), 32'd2);

    // SRAI legal, then with a non-zero upper immediate
    send(0, 4'b1101, 5, 6, 0, 12'h003);
    check("srai_word", bus.mem_wdata, 32'h40335293);
    check("srai_addr", 32'(bus.mem_addr), 32'd2);
    ack_now();
    send(0, 4'b1101, 5, 6, 0, 12'h023);
    check("srai_bad_err",   32'(err), 32'd1);
    check("srai_bad_wr_en", 32'(bus.mem_wr_en), 32'd0);
    @(negedge clk);
    check("srai_bad_err_gone", 32'(err), 32'd0);
    check("srai_bad_addr", 32'(bus.mem_addr), 32'd3);

    // Illegal alternate forms
    send(0, 4'b1000, 1, 1, 0, 0);
    check("i1000_err", 32'(err), 32'd1);
    @(negedge clk);
    check("i1000_err_gone", 32'(err), 32'd0);
    send(1, 4'b1001, 1, 1, 1, 0);
    check("r1001_err", 32'(err), 32'd1);
    check("r1001_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("r1001_err_gone", 32'(err), 32'd0);
    check("illegal_cnt", 32'(word_cnt), 32'd3);

    // Fill to DEPTH with continuous requests and acks
    pulse_clear();
    check("clr_addr", 32'(bus.mem_addr), 32'd0);
    nw0  = nwrites;
    base = wr_addr_q.size();
    drive(0, 4'b0000, 2, 1, 0, 12'h7FF);
    bus.in_valid   = 1'b1;
    bus.mem_wr_ack = 1'b1;
    repeat (14) @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.mem_wr_ack = 1'b0;
    check("fill_full",   32'(full), 32'd1);
    check("fill_ready",  32'(bus.in_ready), 32'd0);
    check("fill_cnt",    32'(word_cnt), 32'd4);
    check("fill_writes", 32'(nwrites - nw0), 32'd4);
    if (wr_addr_q.size() >= base + 4)
      for (int i = 0; i < 4; i++) check("fill_addr", 32'(wr_addr_q[base + i]), 32'(i));
    pulse_clear();
    check("unfull_full",  32'(full), 32'd0);
    check("unfull_ready", 32'(bus.in_ready), 32'd1);
    check("unfull_addr",  32'(bus.mem_addr), 32'd0);

    // clear abandons a pending write
    send(1, 4'b0111, 4, 5, 6, 0);
    ack_now();
    send(1, 4'b0110, 7, 8, 9, 0);
    check("clrw_pending", 32'(bus.mem_wr_en), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clrw_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("clrw_cnt",   32'(word_cnt), 32'd0);
    bus.mem_wr_ack = 1'b1;
    repeat (3) @(negedge clk);
    bus.mem_wr_ack = 1'b0;
    check("clrw_late_ack_cnt", 32'(word_cnt), 32'd0);

    // Asynchronous reset in the middle of a write
    send(0, 4'b0100, 9, 10, 0, 12'h123);
    #2 rst = 1'b1;
    #1;
    check("rstw_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("rstw_wdata", bus.mem_wdata, 32'd0);
    check("rstw_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 31),
            ($urandom_range(0, 1) != 0) ? $urandom_range(0, 31) : $urandom_range(0, 4095));
      bus.in_valid   = ($urandom_range(0, 2) != 0);
      bus.mem_wr_ack = ($urandom_range(0, 1) != 0);
      clear = ($urandom_range(0, 99) == 0) || (m_full && $urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.mem_wr_ack = 1'b0;
    clear          = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
